// File: rtl/regfile_bypass_sb_if.sv
// Decode/writeback-facing bus of the bypassed register file with issue scoreboard.
// The master side drives addresses, write lanes and issue/flush; the slave side returns read data and pending status.
interface regfile_bypass_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] RdAdr1;
  logic [ADDR_W-1:0] RdAdr2;
  logic [DATA_W-1:0] RdDt1;
  logic [DATA_W-1:0] RdDt2;
  logic              Pend1;
  logic              Pend2;
  logic              WrEn0;
  logic [ADDR_W-1:0] WrAdr0;
  logic [DATA_W-1:0] WrDt0;
  logic              WrEn1;
  logic [ADDR_W-1:0] WrAdr1;
  logic [DATA_W-1:0] WrDt1;
  logic              IssEn;
  logic [ADDR_W-1:0] IssAdr;
  logic              Flush;
  logic [ADDR_W:0]   PendCnt;

  modport master (
    output RdAdr1, RdAdr2, WrEn0, WrAdr0, WrDt0, WrEn1, WrAdr1, WrDt1,
           IssEn, IssAdr, Flush,
    input  RdDt1, RdDt2, Pend1, Pend2, PendCnt
  );

  modport slave (
    input  RdAdr1, RdAdr2, WrEn0, WrAdr0, WrDt0, WrEn1, WrAdr1, WrDt1,
           IssEn, IssAdr, Flush,
    output RdDt1, RdDt2, Pend1, Pend2, PendCnt
  );
endinterface

// File: rtl/regfile_bypass_sb.sv
// Two-read/two-write register file with same-cycle write-through bypass.
// Also holds a pending-producer scoreboard with a registered population count.
module regfile_bypass_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic              clk,
  input logic              rst,
  regfile_bypass_sb_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic [NREG-1:0]   pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   sets, clears;

  logic zr;
  logic wv0, wv1, iv;
  logic [DATA_W-1:0] rd1, rd2;
  logic              pn1, pn2;

  assign zr  = (ZERO_REG != 0);
  assign wv0 = bus.WrEn0 && !(zr && (bus.WrAdr0 == '0));
  assign wv1 = bus.WrEn1 && !(zr && (bus.WrAdr1 == '0));
  assign iv  = bus.IssEn && !(zr && (bus.IssAdr == '0));

  function automatic logic [DATA_W-1:0] bypass_data(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] arr,
    input logic              z,
    input logic              v0,
    input logic [ADDR_W-1:0] a0,
    input logic [DATA_W-1:0] d0,
    input logic              v1,
    input logic [ADDR_W-1:0] a1,
    input logic [DATA_W-1:0] d1
  );
    if (z && (a == '0))        return '0;
    else if (v1 && (a1 == a))  return d1;
    else if (v0 && (a0 == a))  return d0;
    else                       return arr;
  endfunction

  function automatic logic bypass_pend(
    input logic              p,
    input logic [ADDR_W-1:0] a,
    input logic              v0,
    input logic [ADDR_W-1:0] a0,
    input logic              v1,
    input logic [ADDR_W-1:0] a1
  );
    return p && !((v0 && (a0 == a)) || (v1 && (a1 == a)));
  endfunction

  always_comb begin
    rd1 = bypass_data(bus.RdAdr1, mem_q[bus.RdAdr1], zr, wv0, bus.WrAdr0, bus.WrDt0,
                      wv1, bus.WrAdr1, bus.WrDt1);
    rd2 = bypass_data(bus.RdAdr2, mem_q[bus.RdAdr2], zr, wv0, bus.WrAdr0, bus.WrDt0,
                      wv1, bus.WrAdr1, bus.WrDt1);
    pn1 = bypass_pend(pend_q[bus.RdAdr1], bus.RdAdr1, wv0, bus.WrAdr0, wv1, bus.WrAdr1);
    pn2 = bypass_pend(pend_q[bus.RdAdr2], bus.RdAdr2, wv0, bus.WrAdr0, wv1, bus.WrAdr1);
  end

  // Outputs are forced quiet while reset is held so an in-flight write cannot leak through the bypass.
  assign bus.RdDt1   = rst ? '0 : rd1;
  assign bus.RdDt2   = rst ? '0 : rd2;
  assign bus.Pend1   = rst ? 1'b0 : pn1;
  assign bus.Pend2   = rst ? 1'b0 : pn2;
  assign bus.PendCnt = cnt_q;

  always_comb begin
    mem_d = mem_q;
    if (wv0) mem_d[bus.WrAdr0] = bus.WrDt0;
    if (wv1) mem_d[bus.WrAdr1] = bus.WrDt1;
  end

  // Issue is applied after the write clears so a new producer supersedes a retiring one.
  always_comb begin
    pend_d = pend_q;
    if (wv0) pend_d[bus.WrAdr0] = 1'b0;
    if (wv1) pend_d[bus.WrAdr1] = 1'b0;
    if (iv)  pend_d[bus.IssAdr] = 1'b1;
    if (bus.Flush) pend_d = '0;
  end

  always_comb begin
    sets   = '0;
    clears = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (pend_d[i] && !pend_q[i]) sets   = sets + (ADDR_W+1)'(1);
      if (!pend_d[i] && pend_q[i]) clears = clears + (ADDR_W+1)'(1);
    end
    cnt_d = bus.Flush ? '0 : (cnt_q + sets - clears);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Scoreboard bench for regfile_bypass_sb: directed vectors plus a randomized run against a reference model.
module tb_regfile_bypass_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_bypass_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       nm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        p1;
    logic        p2;
    logic [5:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
    end
  endtask

  // Monitor: pops one expectation per cycle in which stimulus issued one.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.nm, "RdDt1",   bus.RdDt1, e.rd1);
      cmp(e.nm, "RdDt2",   bus.RdDt2, e.rd2);
      cmp(e.nm, "Pend1",   {31'b0, bus.Pend1}, {31'b0, e.p1});
      cmp(e.nm, "Pend2",   {31'b0, bus.Pend2}, {31'b0, e.p2});
      cmp(e.nm, "PendCnt", {26'b0, bus.PendCnt}, {26'b0, e.cnt});
    end
  end

  task automatic idle();
    bus.RdAdr1 = '0; bus.RdAdr2 = '0;
    bus.WrEn0 = 1'b0; bus.WrAdr0 = '0; bus.WrDt0 = '0;
    bus.WrEn1 = 1'b0; bus.WrAdr1 = '0; bus.WrDt1 = '0;
    bus.IssEn = 1'b0; bus.IssAdr = '0; bus.Flush = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_now(input string nm, input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic p1, input logic p2, input logic [5:0] cnt);
    exp_t e;
    e.nm = nm; e.rd1 = rd1; e.rd2 = rd2; e.p1 = p1; e.p2 = p2; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    bus.RdAdr1 = a1; bus.RdAdr2 = a2;
  endtask
  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    bus.WrEn0 = 1'b1; bus.WrAdr0 = a; bus.WrDt0 = d;
  endtask
  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    bus.WrEn1 = 1'b1; bus.WrAdr1 = a; bus.WrDt1 = d;
  endtask
  task automatic iss(input logic [4:0] a);
    bus.IssEn = 1'b1; bus.IssAdr = a;
  endtask

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  logic [31:0] mem_m [32];
  logic [31:0] pend_m;

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    logic v0, v1;
    v0 = bus.WrEn0 && (bus.WrAdr0 != 0);
    v1 = bus.WrEn1 && (bus.WrAdr1 != 0);
    if (a == 0) return '0;
    if (v1 && bus.WrAdr1 == a) return bus.WrDt1;
    if (v0 && bus.WrAdr0 == a) return bus.WrDt0;
    return mem_m[a];
  endfunction

  function automatic logic model_pend(input logic [4:0] a);
    logic v0, v1;
    v0 = bus.WrEn0 && (bus.WrAdr0 != 0);
    v1 = bus.WrEn1 && (bus.WrAdr1 != 0);
    return pend_m[a] && !((v0 && bus.WrAdr0 == a) || (v1 && bus.WrAdr1 == a));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      expect_now("reset_scan", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
      next();
    end

    wr0(5'd0, 32'hDEADBEEF); wr1(5'd0, 32'hCAFEF00D); rd(5'd0, 5'd0);
    expect_now("x0_write_byp", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0); next();
    rd(5'd0, 5'd0);
    expect_now("x0_after", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0); next();

    wr0(5'd5, 32'h11223344); rd(5'd5, 5'd6);
    expect_now("x5_byp", 32'h11223344, 32'h0, 1'b0, 1'b0, 6'd0); next();
    rd(5'd5, 5'd0);
    expect_now("x5_stored", 32'h11223344, 32'h0, 1'b0, 1'b0, 6'd0); next();

    wr0(5'd7, 32'h0000AAAA); wr1(5'd7, 32'h0000BBBB); rd(5'd7, 5'd0);
    expect_now("x7_lane_prio_byp", 32'h0000BBBB, 32'h0, 1'b0, 1'b0, 6'd0); next();
    rd(5'd7, 5'd5);
    expect_now("x7_lane_prio_arr", 32'h0000BBBB, 32'h11223344, 1'b0, 1'b0, 6'd0); next();

    wr0(5'd11, 32'h1111); wr1(5'd12, 32'h1212); rd(5'd11, 5'd12);
    expect_now("dual_lane_byp", 32'h1111, 32'h1212, 1'b0, 1'b0, 6'd0); next();
    rd(5'd11, 5'd12);
    expect_now("dual_lane_arr", 32'h1111, 32'h1212, 1'b0, 1'b0, 6'd0); next();

    iss(5'd3); rd(5'd3, 5'd0);
    expect_now("iss3_same_cyc", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0); next();
    rd(5'd3, 5'd0);
    expect_now("iss3_pending", 32'h0, 32'h0, 1'b1, 1'b0, 6'd1); next();
    wr0(5'd3, 32'h33); rd(5'd3, 5'd0);
    expect_now("wr3_clear_byp", 32'h33, 32'h0, 1'b0, 1'b0, 6'd1); next();
    rd(5'd3, 5'd0);
    expect_now("wr3_cleared", 32'h33, 32'h0, 1'b0, 1'b0, 6'd0); next();

    iss(5'd0); rd(5'd0, 5'd0);
    expect_now("iss0", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0); next();
    rd(5'd0, 5'd0);
    expect_now("iss0_ignored", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0); next();

    iss(5'd4); rd(5'd4, 5'd0);
    expect_now("iss4", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0); next();
    iss(5'd4); wr1(5'd4, 32'h44); rd(5'd4, 5'd0);
    expect_now("iss_wr4_byp", 32'h44, 32'h0, 1'b0, 1'b0, 6'd1); next();
    rd(5'd4, 5'd0);
    expect_now("iss_wr4_keeps", 32'h44, 32'h0, 1'b1, 1'b0, 6'd1); next();
    iss(5'd8); rd(5'd4, 5'd0);
    expect_now("iss8", 32'h44, 32'h0, 1'b1, 1'b0, 6'd1); next();
    iss(5'd9); rd(5'd8, 5'd0);
    expect_now("iss9", 32'h0, 32'h0, 1'b1, 1'b0, 6'd2); next();
    bus.Flush = 1'b1; iss(5'd10); rd(5'd8, 5'd4);
    expect_now("flush_cyc", 32'h0, 32'h44, 1'b1, 1'b1, 6'd3); next();
    rd(5'd10, 5'd8);
    expect_now("flushed", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0); next();

    iss(5'd1);
    expect_now("iss1", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0); next();
    iss(5'd2);
    expect_now("iss2", 32'h0, 32'h0, 1'b0, 1'b0, 6'd1); next();
    iss(5'd3);
    expect_now("iss3b", 32'h0, 32'h0, 1'b0, 1'b0, 6'd2); next();
    rd(5'd2, 5'd3);
    expect_now("three_pending", 32'h0, 32'h33, 1'b1, 1'b1, 6'd3); next();
    rst = 1'b1; wr1(5'd5, 32'h55); rd(5'd5, 5'd7);
    expect_now("async_rst_held", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0); next();
    rst = 1'b0; rd(5'd5, 5'd3);
    expect_now("after_rst", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0); next();

    for (int i = 0; i < 32; i++) mem_m[i] = '0;
    pend_m = '0;
    for (int n = 0; n < 10000; n++) begin
      logic v0, v1, vi;
      bus.RdAdr1 = raddr(); bus.RdAdr2 = raddr();
      bus.WrEn0 = ($urandom_range(0, 9) < 4); bus.WrAdr0 = raddr(); bus.WrDt0 = $urandom;
      bus.WrEn1 = ($urandom_range(0, 9) < 4); bus.WrAdr1 = raddr(); bus.WrDt1 = $urandom;
      bus.IssEn = ($urandom_range(0, 9) < 5); bus.IssAdr = raddr();
      bus.Flush = ($urandom_range(0, 49) == 0);
      expect_now("rand", model_rd(bus.RdAdr1), model_rd(bus.RdAdr2),
                 model_pend(bus.RdAdr1), model_pend(bus.RdAdr2), 6'($countones(pend_m)));
      v0 = bus.WrEn0 && (bus.WrAdr0 != 0);
      v1 = bus.WrEn1 && (bus.WrAdr1 != 0);
      vi = bus.IssEn && (bus.IssAdr != 0);
      if (v0) mem_m[bus.WrAdr0] = bus.WrDt0;
      if (v1) mem_m[bus.WrAdr1] = bus.WrDt1;
      if (bus.Flush) pend_m = '0;
      else begin
        if (v0) pend_m[bus.WrAdr0] = 1'b0;
        if (v1) pend_m[bus.WrAdr1] = 1'b0;
        if (vi) pend_m[bus.IssAdr] = 1'b1;
      end
      next();
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
